// File: rtl/clk_en_pkg.sv
// Shared definitions for the clock-enable generator.
//   mode_e      : operating mode (RUN / HALT / STEP)
//   decode_mode : maps the raw 2-bit mode input onto mode_e; 2'b11 is HALT
package clk_en_pkg;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_HALT = 2'b01,
    MODE_STEP = 2'b10
  } mode_e;

  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b00:   return MODE_RUN;
      2'b10:   return MODE_STEP;
      default: return MODE_HALT;
    endcase
  endfunction

endpackage

// File: rtl/clk_enable_gen_sync_edge.sv
// Multi-stage synchroniser with rising-edge detector for an asynchronous,
// already-debounced input (board buttons).
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   async_in   : asynchronous level input
//   rise_pulse : one-cycle pulse after the synchronised input rises
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], async_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/clk_enable_gen.sv
// Programmable clock-enable generator with RUN / HALT / single-STEP modes.
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   mode        : 00 RUN, 01 HALT, 10 STEP, 11 HALT
//   div_in      : new divisor value (0 behaves as 1)
//   div_load    : one-cycle strobe capturing div_in into the shadow register
//   step_in     : asynchronous step button (debounced)
//   tick        : registered one-cycle enable pulse
//   sq          : registered square wave, toggles on every tick
//   cnt_o       : current counter value (debug)
//   div_pending : a loaded divisor is waiting to take effect
module clk_enable_gen
  import clk_en_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 1_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  input  logic             step_in,
  output logic             tick,
  output logic             sq,
  output logic [WIDTH-1:0] cnt_o,
  output logic             div_pending
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] div_act, div_act_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic [WIDTH-1:0] d_eff, d_new;
  logic             tick_n, sq_n, pending_n;
  logic             was_run, was_run_n;
  logic             step_rise;
  logic             terminal, transfer;
  mode_e            mode_s;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (step_in),
    .rise_pulse (step_rise)
  );

  assign mode_s = decode_mode(mode);
  assign d_eff  = (div_act == '0) ? ONE : div_act;
  assign d_new  = (shadow  == '0) ? ONE : shadow;

  // Terminal uses >= so a counter stranded above a shrunken divisor still
  // wraps to 0 rather than running through 2^WIDTH.
  assign terminal = (mode_s == MODE_RUN) && was_run && (cnt >= d_eff - ONE);
  // A pending divisor moves across at the RUN wrap, or immediately when not running.
  assign transfer = div_pending && ((mode_s != MODE_RUN) || terminal);

  always_comb begin
    cnt_n     = cnt;
    tick_n    = 1'b0;
    sq_n      = sq;
    div_act_n = div_act;
    shadow_n  = shadow;
    pending_n = div_pending;
    was_run_n = (mode_s == MODE_RUN);

    case (mode_s)
      MODE_RUN: begin
        if (!was_run) begin
          cnt_n = '0;
        end else if (terminal) begin
          cnt_n  = '0;
          tick_n = 1'b1;
          sq_n   = ~sq;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      MODE_STEP: begin
        cnt_n = '0;
        if (step_rise) begin
          tick_n = 1'b1;
          sq_n   = ~sq;
        end
      end
      default: begin
        if (transfer && (cnt >= d_new)) cnt_n = '0;
      end
    endcase

    if (transfer) div_act_n = shadow;

    // A load coinciding with a transfer keeps pending set for the next one.
    if (div_load) begin
      shadow_n  = div_in;
      pending_n = 1'b1;
    end else if (transfer) begin
      pending_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      tick        <= 1'b0;
      sq          <= 1'b0;
      div_act     <= WIDTH'(DEFAULT_DIV);
      shadow      <= '0;
      div_pending <= 1'b0;
      was_run     <= 1'b1;
    end else begin
      cnt         <= cnt_n;
      tick        <= tick_n;
      sq          <= sq_n;
      div_act     <= div_act_n;
      shadow      <= shadow_n;
      div_pending <= pending_n;
      was_run     <= was_run_n;
    end
  end

  assign cnt_o = cnt;

endmodule
